// File: rtl/cond_pkg.sv
// Shared constants for the ARM condition stage.
// Flag bit positions, condition encodings and flag-write bit indices.
package cond_pkg;

   localparam int FLAG_W = 5;

   localparam int FLAG_V = 0;
   localparam int FLAG_C = 1;
   localparam int FLAG_Z = 2;
   localparam int FLAG_N = 3;
   localparam int FLAG_Q = 4;

   localparam int FW_CV = 0;
   localparam int FW_NZ = 1;
   localparam int FW_Q  = 2;

   localparam logic [3:0] COND_EQ = 4'b0000;
   localparam logic [3:0] COND_NE = 4'b0001;
   localparam logic [3:0] COND_CS = 4'b0010;
   localparam logic [3:0] COND_CC = 4'b0011;
   localparam logic [3:0] COND_MI = 4'b0100;
   localparam logic [3:0] COND_PL = 4'b0101;
   localparam logic [3:0] COND_VS = 4'b0110;
   localparam logic [3:0] COND_VC = 4'b0111;
   localparam logic [3:0] COND_HI = 4'b1000;
   localparam logic [3:0] COND_LS = 4'b1001;
   localparam logic [3:0] COND_GE = 4'b1010;
   localparam logic [3:0] COND_LT = 4'b1011;
   localparam logic [3:0] COND_GT = 4'b1100;
   localparam logic [3:0] COND_LE = 4'b1101;
   localparam logic [3:0] COND_AL = 4'b1110;
   localparam logic [3:0] COND_NV = 4'b1111;

endpackage

// File: rtl/cond_eval.sv
// Combinational condition evaluator: Cond field and NZCV flags to pass bit.
// The Q flag is ignored; the reserved encoding never passes.
module cond_eval
   import cond_pkg::*;
(
   input  logic [3:0]        i_cond,
   input  logic [FLAG_W-1:0] i_flags,
   output logic              o_pass
);

   logic w_n;
   logic w_z;
   logic w_c;
   logic w_v;
   logic w_ge;

   assign w_n  = i_flags[FLAG_N];
   assign w_z  = i_flags[FLAG_Z];
   assign w_c  = i_flags[FLAG_C];
   assign w_v  = i_flags[FLAG_V];
   assign w_ge = (w_n == w_v);

   always_comb begin
      o_pass = 1'b0;
      case (i_cond)
         COND_EQ: o_pass = w_z;
         COND_NE: o_pass = ~w_z;
         COND_CS: o_pass = w_c;
         COND_CC: o_pass = ~w_c;
         COND_MI: o_pass = w_n;
         COND_PL: o_pass = ~w_n;
         COND_VS: o_pass = w_v;
         COND_VC: o_pass = ~w_v;
         COND_HI: o_pass = w_c & ~w_z;
         COND_LS: o_pass = ~(w_c & ~w_z);
         COND_GE: o_pass = w_ge;
         COND_LT: o_pass = ~w_ge;
         COND_GT: o_pass = ~w_z & w_ge;
         COND_LE: o_pass = ~(~w_z & w_ge);
         COND_AL: o_pass = 1'b1;
         COND_NV: o_pass = 1'b0;
         default: o_pass = 1'b0;
      endcase
   end

endmodule

// File: rtl/cond_logic.sv
// Condition stage: flag register, latched condition result and
// write-strobe gating for the multicycle ARM controller.
module cond_logic
   import cond_pkg::*;
(
   input  logic              clk,
   input  logic              reset,
   input  logic [3:0]        Cond,
   input  logic [FLAG_W-1:0] ALUFlags,
   input  logic [2:0]        FlagW,
   input  logic              QClr,
   input  logic              CondLatch,
   input  logic              PCS,
   input  logic              NextPC,
   input  logic              RegW,
   input  logic              MemW,
   output logic [FLAG_W-1:0] Flags,
   output logic              CondExReg,
   output logic              PCWrite,
   output logic              RegWrite,
   output logic              MemWrite
);

   logic [FLAG_W-1:0] r_flags;
   logic              r_condex;
   logic              w_pass;
   logic              w_q_set;

   cond_eval u_eval (
      .i_cond  (Cond),
      .i_flags (r_flags),
      .o_pass  (w_pass)
   );

   assign w_q_set = r_condex & FlagW[FW_Q] & ALUFlags[FLAG_Q];

   // Evaluation sees pre-write flags: w_pass is built from r_flags.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_flags  <= '0;
         r_condex <= 1'b0;
      end else begin
         if (CondLatch)
            r_condex <= w_pass;
         if (r_condex & FlagW[FW_NZ]) begin
            r_flags[FLAG_N] <= ALUFlags[FLAG_N];
            r_flags[FLAG_Z] <= ALUFlags[FLAG_Z];
         end
         if (r_condex & FlagW[FW_CV]) begin
            r_flags[FLAG_C] <= ALUFlags[FLAG_C];
            r_flags[FLAG_V] <= ALUFlags[FLAG_V];
         end
         // Sticky Q: a set beats a simultaneous clear.
         if (w_q_set)
            r_flags[FLAG_Q] <= 1'b1;
         else if (QClr)
            r_flags[FLAG_Q] <= 1'b0;
      end
   end

   assign Flags     = r_flags;
   assign CondExReg = r_condex;
   assign PCWrite   = (PCS & r_condex) | NextPC;
   assign RegWrite  = RegW & r_condex;
   assign MemWrite  = MemW & r_condex;

endmodule
